// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: next-PC select encodings,
// fetch-stage state encoding and the default reset vector.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] PC_P4 = 2'b00;
    localparam logic [1:0] PC_BR = 2'b01;
    localparam logic [1:0] PC_JR = 2'b10;
    localparam logic [1:0] PC_J  = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_VALID = 2'b01,
        S_HALT  = 2'b10
    } fetch_state_e;

    // Sign-extended 16-bit word offset, scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/cpu_npc.sv
// Combinational next-PC selection: sequential, branch, register-indirect
// and absolute jump targets, plus a flag for a misaligned jr target.
module cpu_npc
    import cpu_pkg::*;
(
    input  logic [31:0] i_p4,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_ra,
    input  logic [1:0]  i_pcsource,
    output logic [31:0] o_npc,
    output logic        o_misaligned
);

    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_br_target = i_p4 + branch_offset(i_inst[15:0]);
    assign w_j_target  = {i_p4[31:28], i_inst[25:0], 2'b00};

    always_comb begin
        o_npc = i_p4;
        case (i_pcsource)
            PC_P4:   o_npc = i_p4;
            PC_BR:   o_npc = w_br_target;
            PC_JR:   o_npc = i_ra;
            PC_J:    o_npc = w_j_target;
            default: o_npc = i_p4;
        endcase
    end

    // Branch and jump targets are word aligned by construction; only jr can fault.
    assign o_misaligned = (i_pcsource == PC_JR) && (i_ra[1:0] != 2'b00);

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch and next-PC stage: owns PC and IR, fetches over a
// req/ack handshake, and advances the PC when the datapath commits.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] p4,
    input  logic        commit,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra,
    output logic        halted,
    output logic [31:0] icount
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_icount;

    logic [31:0] w_p4;
    logic [31:0] w_npc;
    logic        w_misaligned;
    logic        w_load_inst;
    logic        w_load_pc;
    logic        w_count;

    assign w_p4 = r_pc + 32'd4;

    cpu_npc u_npc (
        .i_p4         (w_p4),
        .i_inst       (r_inst),
        .i_ra         (ra),
        .i_pcsource   (pcsource),
        .o_npc        (w_npc),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake outputs decode from r_state only, never from imem_ack.
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        inst_valid   = 1'b0;
        halted       = 1'b0;
        w_load_inst  = 1'b0;
        w_load_pc    = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_load_inst  = 1'b1;
                    w_next_state = S_VALID;
                end
            end
            S_VALID: begin
                inst_valid = 1'b1;
                if (commit) begin
                    w_count = 1'b1;
                    if (w_misaligned) begin
                        w_next_state = S_HALT;
                    end else begin
                        w_load_pc    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc     <= RESET_PC;
            r_inst   <= 32'h0000_0000;
            r_icount <= 32'h0000_0000;
        end else begin
            if (w_load_inst) begin
                r_inst <= imem_rdata;
            end
            if (w_load_pc) begin
                r_pc <= w_npc;
            end
            if (w_count) begin
                r_icount <= r_icount + 32'd1;
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign p4        = w_p4;
    assign inst      = r_inst;
    assign icount    = r_icount;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: directed vector table, handshake/reset corner cases,
// and randomized fetch/commit traffic against a behavioural PC model.
module tb_cpu_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] p4;
  logic        commit = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] ra = 32'h0;
  logic        halted;
  logic [31:0] icount;

  always #5 clk = ~clk;

  cpu_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .p4         (p4),
    .commit     (commit),
    .pcsource   (pcsource),
    .ra         (ra),
    .halted     (halted),
    .icount     (icount)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_icount;
  logic        m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_npc(input logic [31:0] cur_pc, input logic [31:0] word,
                                          input logic [1:0] src, input logic [31:0] r);
    logic [31:0] seq;
    int          off;
    seq = cur_pc + 32'd4;
    off = int'($signed(word[15:0])) * 4;
    case (src)
      2'd0:    return seq;
      2'd1:    return seq + 32'(off);
      2'd2:    return r;
      default: return (seq & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clrn = 1'b0;
    imem_ack = 1'b0;
    commit = 1'b0;
    step();
    clrn = 1'b1;
    m_pc = TB_RESET_PC;
    m_icount = 32'h0;
    m_halted = 1'b0;
  endtask

  // Wait 'delay' unacked request cycles (optionally with ignored commits), then ack.
  task automatic do_fetch(input logic [31:0] word, input int delay, input bit noise);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      commit = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pcsource = 2'($urandom_range(0, 3));
      ra = $urandom;
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, m_pc);
      step();
    end
    commit = 1'b0;
    chk("ack_cycle_req", 32'(imem_req), 32'd1);
    chk("ack_cycle_valid", 32'(inst_valid), 32'd0);
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    chk("valid_after_ack", 32'(inst_valid), 32'd1);
    chk("req_after_ack", 32'(imem_req), 32'd0);
    chk("inst_loaded", inst, word);
    chk("pc_hold_fetch", pc, m_pc);
  endtask

  // Hold in VALID (optionally with ignored acks), then commit and update the model.
  task automatic do_commit(input logic [1:0] src, input logic [31:0] r, input logic [31:0] word,
                           input int hold, input bit noise);
    for (int i = 0; i < hold; i++) begin
      imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = ~word;
      commit = 1'b0;
      step();
      chk("inst_hold_valid", inst, word);
      chk("pc_hold_valid", pc, m_pc);
      chk("still_valid", 32'(inst_valid), 32'd1);
    end
    imem_ack = 1'b0;
    chk("p4", p4, m_pc + 32'd4);
    commit = 1'b1;
    pcsource = src;
    ra = r;
    step();
    commit = 1'b0;
    m_icount = m_icount + 32'd1;
    if (src == 2'd2 && r[1:0] != 2'b00) m_halted = 1'b1;
    else m_pc = ref_npc(m_pc, word, src, r);
    chk("pc_after_commit", pc, m_pc);
    chk("icount_after_commit", icount, m_icount);
    chk("halted_after_commit", 32'(halted), 32'(m_halted));
    chk("req_after_commit", 32'(imem_req), 32'(!m_halted));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] word;
    logic [1:0]  src;
    logic [31:0] r;
    int          delay;
    int          hold;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] word;
    logic [1:0]  src;
    logic [31:0] r;
    logic [31:0] addr0;

    vecs[0]  = '{32'h2008_0005, 2'b00, 32'h0,         1, 0, 32'h0000_0004};
    vecs[1]  = '{32'h03E0_0008, 2'b10, 32'h0000_0010, 5, 2, 32'h0000_0010};
    vecs[2]  = '{32'h1000_FFFC, 2'b01, 32'h0,         0, 0, 32'h0000_0004};
    vecs[3]  = '{32'h03E0_0008, 2'b10, 32'h1000_0000, 0, 1, 32'h1000_0000};
    vecs[4]  = '{32'h0800_0040, 2'b11, 32'h0,         2, 0, 32'h1000_0100};
    vecs[5]  = '{32'h03E0_0008, 2'b10, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC};
    vecs[6]  = '{32'h0000_0020, 2'b00, 32'h0,         0, 0, 32'h0000_0000};
    vecs[7]  = '{32'h03E0_0008, 2'b10, 32'h0000_0100, 0, 0, 32'h0000_0100};
    vecs[8]  = '{32'h1000_0003, 2'b01, 32'h0,         1, 1, 32'h0000_0110};
    vecs[9]  = '{32'h03E0_0008, 2'b10, 32'hF000_0000, 0, 0, 32'hF000_0000};
    vecs[10] = '{32'h0BFF_FFFF, 2'b11, 32'h0,         0, 0, 32'hFFFF_FFFC};
    vecs[11] = '{32'h0000_0020, 2'b00, 32'h0,         0, 0, 32'h0000_0000};

    // Reset state
    clrn = 1'b0;
    m_pc = TB_RESET_PC;
    m_icount = 32'h0;
    m_halted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, TB_RESET_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_icount", icount, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    clrn = 1'b1;

    // Directed table; row 1 also exercises the 5-cycle stall and acks in VALID
    for (int i = 0; i < 12; i++) begin
      addr0 = imem_addr;
      do_fetch(vecs[i].word, vecs[i].delay, 1'b1);
      do_commit(vecs[i].src, vecs[i].r, vecs[i].word, vecs[i].hold, 1'b1);
      chk("vec_pc", pc, vecs[i].exp_pc);
      chk("vec_icount", icount, 32'(i + 1));
      chk("vec_fetch_addr_was_pc", addr0, (i == 0) ? TB_RESET_PC : vecs[i-1].exp_pc);
    end

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      word = $urandom;
      src = 2'($urandom_range(0, 3));
      r = $urandom & 32'hFFFF_FFFC;
      do_fetch(word, $urandom_range(0, 3), 1'b1);
      do_commit(src, r, word, $urandom_range(0, 2), 1'b1);
    end

    // icount wrap
    force dut.r_icount = 32'hFFFF_FFFF;
    #1;
    release dut.r_icount;
    m_icount = 32'hFFFF_FFFF;
    @(negedge clk);
    do_fetch(32'h0000_0020, 0, 1'b0);
    do_commit(2'b00, 32'h0, 32'h0000_0020, 0, 1'b0);
    chk("icount_wrap", icount, 32'h0);

    // jr fault then sticky halt
    do_fetch(32'h03E0_0008, 0, 1'b0);
    addr0 = m_pc;
    do_commit(2'b10, 32'h0000_0102, 32'h03E0_0008, 0, 1'b0);
    chk("fault_pc_unchanged", pc, addr0);
    chk("fault_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1;
      commit = 1'($urandom_range(0, 1));
      pcsource = 2'b00;
      step();
      chk("halt_no_req", 32'(imem_req), 32'd0);
      chk("halt_not_valid", 32'(inst_valid), 32'd0);
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_pc", pc, addr0);
    end
    imem_ack = 1'b0;
    commit = 1'b0;

    // Reset leaves halt; aligned jr then fetches normally
    apply_reset();
    chk("post_halt_rst_halted", 32'(halted), 32'd0);
    do_fetch(32'h03E0_0008, 0, 1'b0);
    do_commit(2'b10, 32'h0000_0100, 32'h03E0_0008, 0, 1'b0);
    chk("jr_aligned_pc", pc, 32'h0000_0100);
    chk("jr_aligned_addr", imem_addr, 32'h0000_0100);

    // Async reset mid-fetch, with an ack during reset discarded
    do_fetch(32'hDEAD_BEEC, 0, 1'b0);
    do_commit(2'b00, 32'h0, 32'hDEAD_BEEC, 0, 1'b0);
    #2;
    clrn = 1'b0;
    #1;
    chk("async_pc", pc, TB_RESET_PC);
    chk("async_inst", inst, 32'h0);
    chk("async_icount", icount, 32'h0);
    chk("async_req", 32'(imem_req), 32'd1);
    chk("async_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    clrn = 1'b1;
    step();
    chk("rst_ack_discard_inst", inst, 32'h0);
    chk("rst_ack_discard_valid", 32'(inst_valid), 32'd0);
    chk("rst_ack_discard_req", 32'(imem_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
